fwd_hazard_ctrl: RTL and testbench

//  Forwarding and hazard controller for the 5-stage pipeline. Keeps a shadow copy of the

---
 rtl/fwd_hazard_ctrl_if.sv | 35 +++
 rtl/fwd_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_ctrl_if.sv
// Bundle of ID-stage control inputs and forwarding/hazard outputs exchanged
// between the pipeline front end and the forwarding/hazard controller.
interface fwd_hazard_if #(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
);
  logic             id_valid_i;
  logic [RA_W-1:0]  id_rs1_i;
  logic [RA_W-1:0]  id_rs2_i;
  logic             id_use1_i;
  logic             id_use2_i;
  logic [RA_W-1:0]  id_rd_i;
  logic             id_regwr_i;
  logic             id_memrd_i;
  logic             flush_i;
  logic [1:0]       fwd_a_o;
  logic [1:0]       fwd_b_o;
  logic             stall_o;
  logic             bubble_o;
  logic [CNT_W-1:0] stall_cnt_o;

  // pipeline side: presents the ID instruction, consumes the controls
  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_use1_i, id_use2_i,
    output id_rd_i, id_regwr_i, id_memrd_i, flush_i,
    input  fwd_a_o, fwd_b_o, stall_o, bubble_o, stall_cnt_o
  );

  // controller side
  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_use1_i, id_use2_i,
    input  id_rd_i, id_regwr_i, id_memrd_i, flush_i,
    output fwd_a_o, fwd_b_o, stall_o, bubble_o, stall_cnt_o
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller for a 5-stage pipeline.
// Tracks the control fields of the instructions in EX and MEM, drives the
// registered EX operand-mux selects, and generates load-use / RAW stalls.
// The MEM/WB producer is resolved at the edge its consumer enters EX, so no
// WB-stage state is needed beyond what the registered selects already hold.
module fwd_hazard_ctrl #(
  parameter int RA_W   = 5,
  parameter int CNT_W  = 32,
  parameter bit FWD_EN = 1'b1
) (
  input logic          clk_i,
  input logic          rst_i,
  fwd_hazard_if.slave  bus
);

  localparam logic [RA_W-1:0]  REG_X0  = {RA_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  // shadow of the instruction in EX
  logic            ex_valid_r;
  logic [RA_W-1:0] ex_rd_r;
  logic            ex_regwr_r;
  logic            ex_memrd_r;
  // shadow of the instruction in MEM
  logic            mem_valid_r;
  logic [RA_W-1:0] mem_rd_r;
  logic            mem_regwr_r;

  logic [1:0]       fwd_a_r;
  logic [1:0]       fwd_b_r;
  logic [CNT_W-1:0] stall_cnt_r;

  logic       ex_hit1_s;
  logic       ex_hit2_s;
  logic       mem_hit1_s;
  logic       mem_hit2_s;
  logic       raw_s;
  logic       stall_s;
  logic       bubble_s;
  logic       enter_s;
  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;

  // A stage produces r only if it is real, writes a register, and r is not x0.
  function automatic logic writes_reg(input logic            valid,
                                      input logic            regwr,
                                      input logic [RA_W-1:0] rd,
                                      input logic [RA_W-1:0] r);
    return valid && regwr && (rd == r) && (r != REG_X0);
  endfunction

  // dependency detection of the ID instruction against EX and MEM, stall and bubble
  always_comb begin
    ex_hit1_s  = bus.id_use1_i && writes_reg(ex_valid_r,  ex_regwr_r,  ex_rd_r,  bus.id_rs1_i);
    ex_hit2_s  = bus.id_use2_i && writes_reg(ex_valid_r,  ex_regwr_r,  ex_rd_r,  bus.id_rs2_i);
    mem_hit1_s = bus.id_use1_i && writes_reg(mem_valid_r, mem_regwr_r, mem_rd_r, bus.id_rs1_i);
    mem_hit2_s = bus.id_use2_i && writes_reg(mem_valid_r, mem_regwr_r, mem_rd_r, bus.id_rs2_i);
    if (FWD_EN) begin
      // only a load in EX cannot be forwarded in time
      raw_s = (ex_hit1_s || ex_hit2_s) && ex_memrd_r;
    end else begin
      // without forwarding, wait until the producer reaches WB
      raw_s = ex_hit1_s || ex_hit2_s || mem_hit1_s || mem_hit2_s;
    end
    // a flushed instruction is killed, so it never stalls
    stall_s  = bus.id_valid_i && !bus.flush_i && raw_s;
    bubble_s = stall_s || bus.flush_i;
    enter_s  = bus.id_valid_i && !bubble_s;
  end

  // next operand selects for the instruction entering EX; nearest producer wins
  always_comb begin
    fwd_a_s = SEL_RF;
    fwd_b_s = SEL_RF;
    if (FWD_EN && enter_s) begin
      if (ex_hit1_s) begin
        fwd_a_s = SEL_MEM;
      end else if (mem_hit1_s) begin
        fwd_a_s = SEL_WB;
      end else begin
        fwd_a_s = SEL_RF;
      end
      if (ex_hit2_s) begin
        fwd_b_s = SEL_MEM;
      end else if (mem_hit2_s) begin
        fwd_b_s = SEL_WB;
      end else begin
        fwd_b_s = SEL_RF;
      end
    end else begin
      fwd_a_s = SEL_RF;
      fwd_b_s = SEL_RF;
    end
  end

  // advance the shadow stages and register the selects
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_valid_r  <= 1'b0;
      ex_rd_r     <= REG_X0;
      ex_regwr_r  <= 1'b0;
      ex_memrd_r  <= 1'b0;
      mem_valid_r <= 1'b0;
      mem_rd_r    <= REG_X0;
      mem_regwr_r <= 1'b0;
      fwd_a_r     <= SEL_RF;
      fwd_b_r     <= SEL_RF;
    end else begin
      ex_valid_r  <= enter_s;
      ex_rd_r     <= bus.id_rd_i;
      ex_regwr_r  <= bus.id_regwr_i;
      ex_memrd_r  <= bus.id_memrd_i;
      mem_valid_r <= ex_valid_r;
      mem_rd_r    <= ex_rd_r;
      mem_regwr_r <= ex_regwr_r;
      fwd_a_r     <= fwd_a_s;
      fwd_b_r     <= fwd_b_s;
    end
  end

  // saturating count of stalled cycles
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.fwd_a_o     = fwd_a_r;
  assign bus.fwd_b_o     = fwd_b_r;
  assign bus.stall_o     = stall_s;
  assign bus.bubble_o    = bubble_s;
  assign bus.stall_cnt_o = stall_cnt_r;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Randomised + directed bench for fwd_hazard_ctrl. Two instances share the
// ID stimulus: d0 with forwarding (CNT_W=32), d1 without forwarding and a
// 3-bit counter so that saturation is reached. Each is compared every cycle
// against an instruction-level pipeline model.
module tb_fwd_hazard_ctrl;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
  } ins_t;

  logic clk = 1'b0;
  logic rst_n;
  ins_t cur;
  logic flush;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fwd_hazard_if #(.RA_W(5), .CNT_W(32)) b0 ();
  fwd_hazard_if #(.RA_W(5), .CNT_W(3))  b1 ();

  assign b0.id_valid_i = cur.v;   assign b1.id_valid_i = cur.v;
  assign b0.id_rs1_i   = cur.rs1; assign b1.id_rs1_i   = cur.rs1;
  assign b0.id_rs2_i   = cur.rs2; assign b1.id_rs2_i   = cur.rs2;
  assign b0.id_use1_i  = cur.u1;  assign b1.id_use1_i  = cur.u1;
  assign b0.id_use2_i  = cur.u2;  assign b1.id_use2_i  = cur.u2;
  assign b0.id_rd_i    = cur.rd;  assign b1.id_rd_i    = cur.rd;
  assign b0.id_regwr_i = cur.rw;  assign b1.id_regwr_i = cur.rw;
  assign b0.id_memrd_i = cur.mr;  assign b1.id_memrd_i = cur.mr;
  assign b0.flush_i    = flush;   assign b1.flush_i    = flush;

  fwd_hazard_ctrl #(.RA_W(5), .CNT_W(32), .FWD_EN(1'b1)) d0 (.clk_i(clk), .rst_i(rst_n), .bus(b0));
  fwd_hazard_ctrl #(.RA_W(5), .CNT_W(3),  .FWD_EN(1'b0)) d1 (.clk_i(clk), .rst_i(rst_n), .bus(b1));

  // ---------------- reference model: instructions sitting in EX and MEM ----
  ins_t        m_ex  [2];
  ins_t        m_mem [2];
  logic [1:0]  m_fa  [2];
  logic [1:0]  m_fb  [2];
  logic [31:0] m_cnt [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ins_t mk(input logic [4:0] rd, input logic rw, input logic mr,
                              input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2);
    ins_t i;
    i.v = 1'b1; i.rd = rd; i.rw = rw; i.mr = mr;
    i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2;
    return i;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t i;
    i.v   = ($urandom_range(7, 0) != 0);
    i.rd  = 5'($urandom_range(7, 0));
    i.rw  = ($urandom_range(3, 0) != 0);
    i.mr  = ($urandom_range(2, 0) == 0);
    i.rs1 = 5'($urandom_range(7, 0));
    i.u1  = 1'($urandom_range(1, 0));
    i.rs2 = 5'($urandom_range(7, 0));
    i.u2  = 1'($urandom_range(1, 0));
    return i;
  endfunction

  function automatic bit produces(input ins_t p, input logic [4:0] r);
    return p.v && p.rw && (p.rd == r) && (r != 5'd0);
  endfunction

  function automatic bit depends(input ins_t p, input ins_t i);
    return (i.u1 && produces(p, i.rs1)) || (i.u2 && produces(p, i.rs2));
  endfunction

  function automatic bit exp_stall(input int d, input ins_t i, input logic fl);
    if (!i.v || fl) return 1'b0;
    if (d == 0) return depends(m_ex[d], i) && m_ex[d].mr;
    return depends(m_ex[d], i) || depends(m_mem[d], i);
  endfunction

  function automatic logic [1:0] exp_sel(input int d, input logic v, input logic u, input logic [4:0] r);
    if (d == 1 || !v || !u) return 2'b00;
    if (produces(m_ex[d], r))  return 2'b10;
    if (produces(m_mem[d], r)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      m_ex[d] = '0; m_mem[d] = '0; m_fa[d] = 2'b00; m_fb[d] = 2'b00; m_cnt[d] = 32'd0;
    end
  endtask

  task automatic advance(input int d);
    ins_t        e;
    logic        s;
    logic [31:0] cmax;
    s    = exp_stall(d, cur, flush);
    cmax = (d == 0) ? 32'hFFFF_FFFF : 32'd7;
    e    = cur;
    e.v  = cur.v && !(s || flush);
    m_fa[d] = exp_sel(d, e.v, e.u1, e.rs1);
    m_fb[d] = exp_sel(d, e.v, e.u2, e.rs2);
    if (s && m_cnt[d] != cmax) m_cnt[d] = m_cnt[d] + 32'd1;
    m_mem[d] = m_ex[d];
    m_ex[d]  = e;
  endtask

  task automatic check_dut(input int d);
    logic es;
    es = exp_stall(d, cur, flush);
    check($sformatf("d%0d_stall", d),  32'(d ? b1.stall_o  : b0.stall_o),  32'(es));
    check($sformatf("d%0d_bubble", d), 32'(d ? b1.bubble_o : b0.bubble_o), 32'(es || flush));
    check($sformatf("d%0d_fwd_a", d),  32'(d ? b1.fwd_a_o  : b0.fwd_a_o),  32'(m_fa[d]));
    check($sformatf("d%0d_fwd_b", d),  32'(d ? b1.fwd_b_o  : b0.fwd_b_o),  32'(m_fb[d]));
    check($sformatf("d%0d_cnt", d),    d ? 32'(b1.stall_cnt_o) : b0.stall_cnt_o, m_cnt[d]);
  endtask

  // present one ID instruction for one cycle, starting and ending on a negedge
  task automatic step(input ins_t i, input logic fl, input int k, output logic st);
    cur = i; flush = fl;
    #1;
    check_dut(0);
    check_dut(1);
    st = exp_stall(k, i, fl);
    @(posedge clk);
    advance(0);
    advance(1);
    @(negedge clk);
  endtask

  // present an instruction until instance k accepts it; n = stalled cycles
  task automatic issue(input ins_t i, input int k, output int n);
    logic st;
    logic done;
    n = 0; done = 1'b0; st = 1'b0;
    for (int c = 0; c < 4 && !done; c++) begin
      step(i, 1'b0, k, st);
      if (st) n++;
      else done = 1'b1;
    end
    if (!done) check("issue_bound", 32'(st), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    reset_model();
    check("rst_fwd_a",  32'(b0.fwd_a_o),  32'd0);
    check("rst_fwd_b",  32'(b0.fwd_b_o),  32'd0);
    check("rst_stall",  32'(b0.stall_o),  32'd0);
    check("rst_cnt",    b0.stall_cnt_o,   32'd0);
    check("rst_stall1", 32'(b1.stall_o),  32'd0);
    check("rst_cnt1",   32'(b1.stall_cnt_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  ins_t nop, nxt;
  logic st, fl;
  int   n;

  initial begin
    nop   = '0;
    cur   = '0;
    flush = 1'b0;
    rst_n = 1'b0;
    reset_model();
    @(negedge clk);
    do_reset();

    // load-use: lw x5,0(x1) ; add x6,x5,x5
    issue(mk(5'd5, 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0), 0, n);
    issue(mk(5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1), 0, n);
    check("t4_stalls", 32'(n), 32'd1);
    check("t4_fwd_a",  32'(b0.fwd_a_o), 32'd1);
    check("t4_fwd_b",  32'(b0.fwd_b_o), 32'd1);
    check("t4_cnt",    b0.stall_cnt_o, 32'd1);

    // add x5,x1,x2 ; sub x6,x5,x3
    issue(mk(5'd5, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1), 0, n);
    issue(mk(5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd3, 1'b1), 0, n);
    check("t2_stalls", 32'(n), 32'd0);
    check("t2_fwd_a",  32'(b0.fwd_a_o), 32'd2);
    check("t2_fwd_b",  32'(b0.fwd_b_o), 32'd0);

    // add x5 ; nop ; or x7,x4,x5
    issue(mk(5'd5, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1), 0, n);
    issue(nop, 0, n);
    issue(mk(5'd7, 1'b1, 1'b0, 5'd4, 1'b1, 5'd5, 1'b1), 0, n);
    check("t3_fwd_a", 32'(b0.fwd_a_o), 32'd0);
    check("t3_fwd_b", 32'(b0.fwd_b_o), 32'd1);
    // two producers of x5: nearest wins
    issue(mk(5'd5, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1), 0, n);
    issue(mk(5'd5, 1'b1, 1'b0, 5'd3, 1'b1, 5'd2, 1'b1), 0, n);
    issue(mk(5'd7, 1'b1, 1'b0, 5'd4, 1'b1, 5'd5, 1'b1), 0, n);
    check("t3_near_b", 32'(b0.fwd_b_o), 32'd2);

    // lw x0 ; add x6,x0,x0 : x0 never hazards
    issue(mk(5'd0, 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0), 0, n);
    issue(mk(5'd6, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1), 0, n);
    check("t5_x0_stalls", 32'(n), 32'd0);
    check("t5_x0_fwd_a",  32'(b0.fwd_a_o), 32'd0);
    check("t5_x0_fwd_b",  32'(b0.fwd_b_o), 32'd0);
    // lw x5 ; dependent flushed: bubble only, nothing enters EX
    issue(mk(5'd5, 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0), 0, n);
    cur = mk(5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1); flush = 1'b1;
    #1;
    check("t5_flush_stall",  32'(b0.stall_o),  32'd0);
    check("t5_flush_bubble", 32'(b0.bubble_o), 32'd1);
    #1;
    step(cur, 1'b1, 0, st);
    check("t5_flush_fwd_a", 32'(b0.fwd_a_o), 32'd0);

    // reset in the middle of a load-use stall
    issue(mk(5'd5, 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0), 0, n);
    cur = mk(5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1); flush = 1'b0;
    #1;
    check("t1_pre_stall", 32'(b0.stall_o), 32'd1);
    do_reset();

    // no forwarding: add x5 ; sub x6,x5,x3 stalls two cycles
    issue(mk(5'd5, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1), 1, n);
    issue(mk(5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd3, 1'b1), 1, n);
    check("t6_stalls", 32'(n), 32'd2);
    check("t6_cnt",    32'(b1.stall_cnt_o), 32'd2);
    check("t6_fwd_a",  32'(b1.fwd_a_o), 32'd0);
    check("t6_fwd_b",  32'(b1.fwd_b_o), 32'd0);

    // random traffic, upstream held by each instance in turn
    for (int k = 0; k < 2; k++) begin
      do_reset();
      st = 1'b0;
      nxt = nop;
      for (int c = 0; c < 400; c++) begin
        if (!st) nxt = rnd_ins();
        fl = ($urandom_range(9, 0) == 0);
        step(nxt, fl, k, st);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
